// File: rtl/priority_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : priority_encoder_pkg
//  Description : Shared constants, FSM state type and helper functions for
//                the registered 8-to-3 priority encoder.
//                  N_REQ      - number of request lines (8)
//                  IDX_W      - index width (3)
//                  state_t    - IDLE / PRESENT
//                  encode_msb - index of the highest set bit (0 if none)
//                  popcount8  - number of set bits in an 8-bit vector
//  Revision    : 1.0 - initial release
// ============================================================================
package priority_encoder_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Ascending scan: the last set bit seen is the highest one.
    function automatic logic [IDX_W-1:0] encode_msb(input logic [N_REQ-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] popcount8(input logic [N_REQ-1:0] vec);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cnt = cnt + {3'b000, vec[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prio_enc_core.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc_core
//  Description : Combinational 8-to-3 priority encoder, bit 7 highest.
//  Ports       : i_req [7:0] - request vector
//                o_idx [2:0] - index of highest set bit (0 when none set)
//                o_any       - at least one bit of i_req is set
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_core
    import priority_encoder_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    assign o_idx = encode_msb(i_req);
    assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : priority_encoder
//  Description : Registered 8-to-3 priority encoder with request latching and
//                a valid/acknowledge handshake. Requests collect in a pending
//                register; the highest pending index is presented on Y with V
//                until ACK, with no pre-emption while presenting.
//  Ports       : CLK        - clock, rising edge
//                RST_N      - asynchronous active-low reset
//                A   [7:0]  - request lines, bit i requests index i
//                E          - capture enable (pending bits are kept when low)
//                ACK        - consumer accepts the presented index
//                Y   [2:0]  - presented index (registered)
//                V          - Y valid (registered)
//                CNT [3:0]  - number of pending requests (registered)
//  Config      : PRIORITY_ENCODER_EDGE_EN - when defined, only 0->1
//                transitions of A (qualified by E) are captured; otherwise
//                capture is level-sensitive.
//  Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_REQ-1:0] A,
    input  logic             E,
    input  logic             ACK,
    output logic [IDX_W-1:0] Y,
    output logic             V,
    output logic [3:0]       CNT
);

    import priority_encoder_pkg::*;

    state_t           r_state;
    logic [N_REQ-1:0] r_p;
    logic [IDX_W-1:0] r_y;
    logic             r_v;
    logic [3:0]       r_cnt;

    logic [N_REQ-1:0] w_cap;
    logic [N_REQ-1:0] w_clr;
    logic [N_REQ-1:0] w_p_next;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;

`ifdef PRIORITY_ENCODER_EDGE_EN
    // A_d follows A on every edge regardless of E, so a rise seen while E is
    // low is consumed and never captured later.
    logic [N_REQ-1:0] r_a_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_a_d <= '0;
        end else begin
            r_a_d <= A;
        end
    end

    assign w_cap = E ? (A & ~r_a_d) : '0;
`else
    assign w_cap = E ? A : '0;
`endif

    // Only an acknowledged, valid index is cleared; ACK in IDLE does nothing.
    assign w_clr = (r_v && ACK) ? ({{(N_REQ-1){1'b0}}, 1'b1} << r_y) : '0;

    // Set wins over clear so a re-request in the ack cycle stays pending.
    assign w_p_next = (r_p & ~w_clr) | w_cap;

    prio_enc_core u_core (
        .i_req (w_p_next),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_p     <= '0;
            r_y     <= '0;
            r_v     <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_p   <= w_p_next;
            r_cnt <= popcount8(w_p_next);
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= PRESENT;
                        r_y     <= w_idx;
                        r_v     <= 1'b1;
                    end
                end
                PRESENT: begin
                    // Y is frozen until ACK: later higher-priority arrivals wait.
                    if (ACK) begin
                        if (w_any) begin
                            r_y <= w_idx;
                        end else begin
                            r_state <= IDLE;
                            r_v     <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_v     <= 1'b0;
                end
            endcase
        end
    end

    assign Y   = r_y;
    assign V   = r_v;
    assign CNT = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_priority_encoder
//  Description : Self-checking bench for priority_encoder. A behavioural
//                model predicts {V,Y,CNT} for each driven cycle, pushes it to
//                a scoreboard queue, and the entry is popped and compared
//                after the clock edge. Directed constant checks follow the
//                test-plan scenarios. Honours PRIORITY_ENCODER_EDGE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_encoder;

    logic       CLK;
    logic       RST_N;
    logic [7:0] A;
    logic       E;
    logic       ACK;
    logic [2:0] Y;
    logic       V;
    logic [3:0] CNT;

    priority_encoder #(.N_REQ(8), .IDX_W(3)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .A     (A),
        .E     (E),
        .ACK   (ACK),
        .Y     (Y),
        .V     (V),
        .CNT   (CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       v;
        logic [2:0] y;
        logic [3:0] cnt;
    } exp_t;

    exp_t q_exp[$];

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    logic [7:0] m_p;
    logic [2:0] m_y;
    logic       m_v;
    logic [7:0] m_ad;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_p  = '0;
        m_y  = '0;
        m_v  = 1'b0;
        m_ad = '0;
    endtask

    // Drive one cycle (called at a falling edge), predict, compare after edge.
    task automatic step(input logic [7:0] a, input logic e, input logic ack);
        logic [7:0] cap;
        logic [7:0] clr;
        logic [7:0] pn;
        exp_t       ex;
        exp_t       got;
        A   = a;
        E   = e;
        ACK = ack;
`ifdef PRIORITY_ENCODER_EDGE_EN
        cap = e ? (a & ~m_ad) : 8'h00;
`else
        cap = e ? a : 8'h00;
`endif
        m_ad = a;
        clr  = 8'h00;
        if (m_v && ack) clr[m_y] = 1'b1;
        pn = (m_p & ~clr) | cap;
        if (!m_v || ack) begin
            if (pn != 8'h00) begin
                m_v = 1'b1;
                for (int i = 7; i >= 0; i--) begin
                    if (pn[i]) begin
                        m_y = 3'(i);
                        break;
                    end
                end
            end else begin
                m_v = 1'b0;
            end
        end
        m_p    = pn;
        ex.v   = m_v;
        ex.y   = m_y;
        ex.cnt = 4'($countones(pn));
        q_exp.push_back(ex);
        @(posedge CLK);
        #1;
        check_val("sb_depth", q_exp.size(), 1);
        got = q_exp.pop_front();
        check_val("sb_V", V, got.v);
        if (got.v) check_val("sb_Y", Y, got.y);
        check_val("sb_CNT", CNT, got.cnt);
        @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        A     = 8'hFF;
        E     = 1'b1;
        ACK   = 1'b0;
        model_reset();

        // Reset holds everything at zero even with all lines requesting
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_Y", Y, 0);
        check_val("rst_V", V, 0);
        check_val("rst_CNT", CNT, 0);

        @(negedge CLK);
        RST_N = 1'b1;
        step(8'hFF, 1'b1, 1'b0);
        check_val("post_rst_V", V, 1);
        check_val("post_rst_Y", Y, 7);
        check_val("post_rst_CNT", CNT, 8);

        // Drain all eight: 7 down to 0, one per cycle
        for (int i = 0; i < 8; i++) step(8'h00, 1'b1, 1'b1);
        check_val("drain8_V", V, 0);

        // Priority and no pre-emption
        step(8'h05, 1'b1, 1'b0);
        check_val("prio_Y", Y, 2);
        check_val("prio_CNT", CNT, 2);
        step(8'h80, 1'b1, 1'b0);
        check_val("nopreempt_Y", Y, 2);
        check_val("nopreempt_CNT", CNT, 3);
        step(8'h00, 1'b1, 1'b1);
        check_val("ack_next_Y", Y, 7);
        step(8'h00, 1'b1, 1'b1);
        check_val("ack_then_Y", Y, 0);
        step(8'h00, 1'b1, 1'b1);
        check_val("prio_empty_V", V, 0);

        // Back-to-back drain of 8'hA1
        step(8'hA1, 1'b1, 1'b0);
        check_val("b2b_Y0", Y, 7);
        step(8'h00, 1'b1, 1'b1);
        check_val("b2b_Y1", Y, 5);
        step(8'h00, 1'b1, 1'b1);
        check_val("b2b_Y2", Y, 0);
        step(8'h00, 1'b1, 1'b1);
        check_val("b2b_V", V, 0);
        check_val("b2b_CNT", CNT, 0);

        // Simultaneous set and clear of the presented bit
        step(8'h08, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        check_val("sc_pre_Y", Y, 3);
        step(8'h08, 1'b1, 1'b1);
        check_val("sc_V", V, 1);
        check_val("sc_Y", Y, 3);
        check_val("sc_CNT", CNT, 1);
        step(8'h00, 1'b1, 1'b1);
        check_val("sc_drain_V", V, 0);

        // Enable gating
        step(8'h10, 1'b0, 1'b0);
        check_val("en_low_V", V, 0);
        step(8'h10, 1'b1, 1'b0);
`ifdef PRIORITY_ENCODER_EDGE_EN
        check_val("en_edge_V", V, 0);
`else
        check_val("en_level_V", V, 1);
        check_val("en_level_Y", Y, 4);
`endif
        // Held line while acking: level mode re-pends it
        step(8'h10, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b1);
        check_val("en_drain_V", V, 0);

        // Mid-operation asynchronous reset
        step(8'h3C, 1'b1, 1'b0);
        check_val("mid_pre_Y", Y, 5);
        check_val("mid_pre_CNT", CNT, 4);
        step(8'h00, 1'b1, 1'b0);
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        check_val("mid_rst_V", V, 0);
        check_val("mid_rst_Y", Y, 0);
        check_val("mid_rst_CNT", CNT, 0);
        @(negedge CLK);
        A     = 8'h00;
        RST_N = 1'b1;
        step(8'h00, 1'b1, 1'b0);
        check_val("mid_after_V", V, 0);
        step(8'h00, 1'b1, 1'b0);

        // Randomised traffic against the model
        for (int i = 0; i < 200; i++) begin
            logic [7:0] ra;
            ra = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) ra = 8'h00;
            step(ra, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
        end
        for (int i = 0; i < 10; i++) step(8'h00, 1'b1, 1'b1);
        check_val("final_V", V, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/priority_encoder.md
# priority_encoder

Registered 8-to-3 priority encoder with request latching and a valid/acknowledge handshake. It is the inverse of the 3-to-8 one-hot decoder already in the practical-lab designs. Request lines are captured into a pending register, and the highest-numbered pending line is presented as a 3-bit index until the consumer acknowledges it. Typical use is to collect interrupt or event lines and feed the index back into the decoder or to a controller.

## Interface
Parameters:
- N_REQ, 8: number of request lines; only 8 is supported.
- IDX_W, 3: index width, equal to log2(N_REQ).

Ports:
- CLK, input, 1: single clock; all state changes on the rising edge.
- RST_N, input, 1: reset, asynchronous, active-low.
- A, input, 8: request lines; bit i requests index i.
- E, input, 1: capture enable. When low, A is ignored, but already-pending requests are still served.
- ACK, input, 1: consumer accepts the presented index.
- Y, output, 3: presented index, registered.
- V, output, 1: Y is valid, registered.
- CNT, output, 4: number of pending requests (0..8), registered.

## Operation
- Pending register P[7:0]. Capture mask C = E ? A : 0 (edge-qualified when the macro below is defined). Clear mask K = one-hot(Y) when V=1 and ACK=1; otherwise K = 0.
- On every edge, P_next = (P & ~K) | C. Set wins over clear: if an acked bit is re-requested in the same cycle, it stays pending.
- Priority: bit 7 is highest, bit 0 is lowest.
- FSM, two states:
  - IDLE (V=0): at the edge, if P_next != 0, go to PRESENT with Y = highest set index of P_next. Otherwise stay in IDLE.
  - PRESENT (V=1): Y is held stable while ACK=0. There is no pre-emption: a higher-priority arrival waits.
  - PRESENT with ACK=1: if P_next != 0, stay in PRESENT with Y = encode(P_next), giving back-to-back service. Otherwise go to IDLE.
- ACK while V=0 is ignored.
- CNT_next = popcount(P_next).
- Reset values: P=0, Y=0, V=0, CNT=0, FSM=IDLE, edge register=0.
- Reset asserted mid-operation discards all pending requests immediately; the first capture after release follows normal rules.

## Timing
- Latency: A sampled high at edge k with E=1 and FSM in IDLE gives V=1 and the correct Y after edge k.
- Throughput: one index per cycle when ACK is held high and requests are pending.
- Y and V only change on a clock edge or on reset; the outputs contain no combinational path from the inputs.
- E low at an edge blocks capture at that edge only. Pending bits are never flushed by E.

## Configuration
- PRIORITY_ENCODER_EDGE_EN:
  - Defined: a register A_d samples A on every edge, regardless of E, and C = E ? (A & ~A_d) : 0. Only 0→1 transitions capture, so a line held high is captured once. A rising edge that occurs while E=0 is lost.
  - Undefined: level mode, C = E ? A : 0. A line held high re-pends itself immediately after each ACK.

## Structure
- Package priority_encoder_pkg:
  - constants N_REQ=8 and IDX_W=3;
  - FSM state typedef (IDLE, PRESENT);
  - function encode_msb(8-bit) returning a 3-bit index;
  - function popcount8 returning 4 bits.
- One combinational sub-module, prio_enc_core: 8-bit input, outputs a 3-bit index and an any-set flag. It is used on P_next.

## Test plan
- Reset: hold RST_N=0 with A=8'hFF, E=1. Expect Y=0, V=0, CNT=0. Release reset; after the first edge expect V=1, Y=7, CNT=8.
- Priority and no pre-emption:
  - Pulse A=8'h05 for one cycle. Expect Y=2, V=1, CNT=2.
  - Pulse A=8'h80 while Y=2 is held without ACK. Expect Y to stay 2 and CNT=3.
  - Assert ACK. Expect Y=7 on the next cycle, then Y=0.
- Back-to-back drain: P=8'hA1 with ACK held high. Expect Y sequence 7, 5, 0 on consecutive cycles, then V=0 and CNT=0.
- Simultaneous set/clear: Y=3, V=1; pulse A=8'h08 in the same cycle as ACK. Expect V=1, Y=3, CNT unchanged.
- Enable: E=0 with A=8'h10. Expect V to stay 0. Raise E; in level mode expect Y=4 one edge later. With PRIORITY_ENCODER_EDGE_EN, expect no capture because A was already high.
- Mid-operation reset: P=8'h3C, V=1; assert RST_N=0 between edges. Expect V, Y and CNT at 0 immediately. After release with A=0, expect V to stay 0.
